format_scan_queue: RTL and testbench
====================================

Name: format_scan_queue

Overview:
- Parametrised successor to the single-lane decode stage-1 format scanner.
- Accepts a fetch group of up to FetchWidth instructions per cycle and classifies each lane's primary opcode into the one-hot-per-format OR'd bitfield.
- Buffers classified entries in an in-order FIFO with ready/stall backpressure and flush, then issues one instruction per cycle to the format-specific decoders.
- Sits between fetch and decode stage 2.

Parameters:
- FetchWidth, 4, instruction lanes per fetch group (1..8)
- Depth, 16, FIFO entries; power of two, >= FetchWidth
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- opcodeSize, 6, primary opcode width
- FormatWidth, 25, format bitfield width (A=bit value 2**0 … Z23=2**24)

Ports:
- clock_i  in  1  clock, rising edge
- resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered and output-stage instructions
- fetchValid_i  in  1  fetch group present
- fetchLaneMask_i  in  FetchWidth  per-lane valid; bit k = lane k
- instructions_i  in  FetchWidth*instructionWidth  lane k at slice k, lane 0 oldest
- baseAddress_i  in  addressWidth  address of lane 0
- instructionPid_i  in  PidSize  group PID
- instructionTid_i  in  TidSize  group TID
- baseMajId_i  in  instructionCounterWidth  major ID of first valid lane
- fetchReady_o  out  1  FIFO can accept a full group this cycle
- stall_i  in  1  downstream stall
- outputEnable_o  out  1  output stage holds a valid instruction
- instFormat_o  out  FormatWidth  format bitfield
- instOpcode_o  out  opcodeSize  instruction bits [0:5]
- instruction_o  out  instructionWidth  raw instruction
- instructionAddress_o  out  addressWidth  address
- instructionPid_o  out  PidSize  PID
- instructionTid_o  out  TidSize  TID
- instructionMajId_o  out  instructionCounterWidth  major ID
- illegal_o  out  1  opcode has no format (bitfield zero)
- occupancy_o  out  $clog2(Depth)+1  FIFO entries in use

Behaviour:
- Reset (resetn_i low, async): every output is 0, including fetchReady_o. Head, tail and occupancy are 0.
  - After release, fetchReady_o = 1.
  - Reset mid-operation discards all contents.
- fetchReady_o = (Depth - occupancy >= FetchWidth), combinational from registered occupancy.
- Push: on an edge with fetchValid_i & fetchReady_o & !flush_i, set bits of fetchLaneMask_i are written in ascending lane order to consecutive FIFO slots.
  - Each valid lane k is classified combinationally before the write.
  - Address = baseAddress_i + 4*k, using physical lane index; addresses wrap modulo 2**addressWidth.
  - MajId = baseMajId_i + rank, where rank = number of valid lanes below k.
  - An empty mask is a no-op.
  - fetchValid_i while !fetchReady_o is dropped; fetch must hold the group until it sees ready.
- Pop: on an edge with !stall_i & !flush_i:
  - If occupancy > 0, the head entry loads into the output registers and outputEnable_o = 1.
  - If empty, outputEnable_o = 0.
- stall_i = 1: output registers and outputEnable_o hold; no pop.
- Simultaneous push and pop: occupancy_next = occupancy + popcount(mask) - pop.
- Latency: a group pushed at edge N gives its first lane at the output after edge N+1. Subsequent lanes follow one per unstalled cycle, in program order.
- Flush (synchronous, highest priority): occupancy and pointers are cleared and outputEnable_o = 0 after the edge. A same-cycle push is discarded.
- Pointers wrap modulo Depth.
- Classification follows the Power ISA v3.0B primary-opcode map; a multi-format opcode ORs its bits. Required anchors:
  - 18 → I (0x40)
  - 16 → B (0x2)
  - 17 → SC (0x400)
  - 14 → D (0x4)
  - 30 → MD|MDS (0x300)
  - 0 → 0, with illegal = 1

Decomposition:
- Shared package format_scan_pkg holds:
  - format bit constants A..Z23
  - FormatWidth
  - the 64-entry opcode→format constant table
- Sub-module format_lut: combinational, opcode in → format bitfield and illegal out. Instantiated FetchWidth times on the push side.
- FIFO storage stays inline.

Test Plan:
- Reset then single group: mask 4'b1111, opcodes 18,16,17,14, base 0x1000, MajId 100.
  - Outputs over 4 cycles: format 0x40/0x2/0x400/0x4, addresses 0x1000/0x1004/0x1008/0x100C, MajIds 100..103.
- Sparse mask 4'b1010, base 0x2000, MajId 7.
  - Two outputs: address 0x2004 MajId 7, then address 0x200C MajId 8.
- Fill: push 4 full groups with stall_i = 1.
  - occupancy_o reaches 15 (one entry in output stage) or 16, and fetchReady_o = 0 once free < 4.
  - A fifth group is not accepted.
  - Release stall: 16 instructions emerge in order.
- Simultaneous push and pop at steady state: occupancy_o stays constant when pushing 1 lane and popping 1 per cycle over 20 cycles.
  - Verify pointer wrap with MajIds contiguous.
- Flush with 9 entries plus a same-cycle push.
  - Next cycle: occupancy_o = 0, outputEnable_o = 0, fetchReady_o = 1; no pushed entry ever appears.
- Opcode 0 and async reset mid-stream.
  - Opcode 0 gives illegal_o = 1 with format 0.
  - Asserting resetn_i low mid-stream zeroes all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/format_scan_pkg.sv
// Shared format bitfield constants and the primary-opcode to instruction-format table.
// A multi-format opcode carries the OR of every format it can take.
package format_scan_pkg;

  localparam int unsigned FormatWidth = 25;
  localparam int unsigned OpcodeBits  = 6;

  typedef logic [FormatWidth-1:0] format_t;

  localparam format_t FmtA   = format_t'(1 << 0);
  localparam format_t FmtB   = format_t'(1 << 1);
  localparam format_t FmtD   = format_t'(1 << 2);
  localparam format_t FmtDQ  = format_t'(1 << 3);
  localparam format_t FmtDS  = format_t'(1 << 4);
  localparam format_t FmtDX  = format_t'(1 << 5);
  localparam format_t FmtI   = format_t'(1 << 6);
  localparam format_t FmtM   = format_t'(1 << 7);
  localparam format_t FmtMD  = format_t'(1 << 8);
  localparam format_t FmtMDS = format_t'(1 << 9);
  localparam format_t FmtSC  = format_t'(1 << 10);
  localparam format_t FmtVA  = format_t'(1 << 11);
  localparam format_t FmtVC  = format_t'(1 << 12);
  localparam format_t FmtVX  = format_t'(1 << 13);
  localparam format_t FmtX   = format_t'(1 << 14);
  localparam format_t FmtXFL = format_t'(1 << 15);
  localparam format_t FmtXFX = format_t'(1 << 16);
  localparam format_t FmtXL  = format_t'(1 << 17);
  localparam format_t FmtXO  = format_t'(1 << 18);
  localparam format_t FmtXS  = format_t'(1 << 19);
  localparam format_t FmtXX2 = format_t'(1 << 20);
  localparam format_t FmtXX3 = format_t'(1 << 21);
  localparam format_t FmtXX4 = format_t'(1 << 22);
  localparam format_t FmtZ22 = format_t'(1 << 23);
  localparam format_t FmtZ23 = format_t'(1 << 24);

  // Index = primary opcode; zero marks an opcode with no defined format.
  localparam format_t OpcodeFormat [64] = '{
    '0, '0, FmtD, FmtD, FmtVA | FmtVC | FmtVX, '0, '0, FmtD,
    FmtD, '0, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD,
    FmtB, FmtSC, FmtI, FmtXL | FmtDX, FmtM, FmtM, '0, FmtM,
    FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtMD | FmtMDS, FmtX | FmtXFX | FmtXO | FmtXS | FmtA,
    FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD,
    FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD,
    FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD, FmtD,
    FmtDQ, FmtDS, FmtDS, FmtA | FmtX | FmtZ22 | FmtZ23,
    FmtXX2 | FmtXX3 | FmtXX4, FmtDQ | FmtDS, FmtDS, FmtA | FmtX | FmtXFL | FmtZ22 | FmtZ23
  };

  function automatic format_t classify(input logic [OpcodeBits-1:0] opcode);
    return OpcodeFormat[opcode];
  endfunction

endpackage

// File: rtl/format_scan_queue_lut.sv
// Combinational primary-opcode classifier for one fetch lane.
module format_lut
  import format_scan_pkg::*;
(
  input  logic [OpcodeBits-1:0] opcode,
  output format_t               format,
  output logic                  illegal
);

  assign format  = classify(opcode);
  assign illegal = (format == '0);

endmodule

// File: rtl/format_scan_queue.sv
// Fetch-group format scanner: classifies up to FetchWidth lanes per cycle, buffers them
// in order and issues one classified instruction per unstalled cycle.
module format_scan_queue
  import format_scan_pkg::*;
#(
  parameter int unsigned FetchWidth              = 4,
  parameter int unsigned Depth                   = 16,
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned opcodeSize              = 6
) (
  input  logic                                   clock_i,
  input  logic                                   resetn_i,
  input  logic                                   flush_i,
  input  logic                                   fetchValid_i,
  input  logic [FetchWidth-1:0]                  fetchLaneMask_i,
  input  logic [FetchWidth*instructionWidth-1:0] instructions_i,
  input  logic [addressWidth-1:0]                baseAddress_i,
  input  logic [PidSize-1:0]                     instructionPid_i,
  input  logic [TidSize-1:0]                     instructionTid_i,
  input  logic [instructionCounterWidth-1:0]     baseMajId_i,
  output logic                                   fetchReady_o,
  input  logic                                   stall_i,
  output logic                                   outputEnable_o,
  output logic [FormatWidth-1:0]                 instFormat_o,
  output logic [opcodeSize-1:0]                  instOpcode_o,
  output logic [instructionWidth-1:0]            instruction_o,
  output logic [addressWidth-1:0]                instructionAddress_o,
  output logic [PidSize-1:0]                     instructionPid_o,
  output logic [TidSize-1:0]                     instructionTid_o,
  output logic [instructionCounterWidth-1:0]     instructionMajId_o,
  output logic                                   illegal_o,
  output logic [$clog2(Depth):0]                 occupancy_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned RankW = $clog2(FetchWidth + 1);

  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] occ_q;

  logic [instructionWidth-1:0]        ins_mem  [Depth];
  logic [addressWidth-1:0]            addr_mem [Depth];
  logic [instructionCounterWidth-1:0] maj_mem  [Depth];
  logic [PidSize-1:0]                 pid_mem  [Depth];
  logic [TidSize-1:0]                 tid_mem  [Depth];
  format_t                            fmt_mem  [Depth];
  logic                               ill_mem  [Depth];

  format_t                  lane_fmt  [FetchWidth];
  logic [FetchWidth-1:0]    lane_ill;
  logic [PtrW-1:0]          lane_slot [FetchWidth];
  logic [RankW-1:0]         lane_rank [FetchWidth];
  logic [RankW-1:0]         push_cnt;
  logic                     push, pop;

  logic                               oe_q, ill_q;
  format_t                            fmt_q;
  logic [instructionWidth-1:0]        ins_q;
  logic [addressWidth-1:0]            addr_q;
  logic [instructionCounterWidth-1:0] maj_q;
  logic [PidSize-1:0]                 pid_q;
  logic [TidSize-1:0]                 tid_q;

  // Gated by the reset pin so ready reads 0 while reset is held, without waiting for an edge.
  assign fetchReady_o = resetn_i && ((CntW'(Depth) - occ_q) >= CntW'(FetchWidth));
  assign push = fetchValid_i & fetchReady_o & ~flush_i;
  assign pop  = ~stall_i & ~flush_i & (occ_q != '0);

  for (genvar k = 0; k < FetchWidth; k++) begin : g_lane
    format_lut u_lut (
      .opcode  (instructions_i[k*instructionWidth + instructionWidth - 1 -: OpcodeBits]),
      .format  (lane_fmt[k]),
      .illegal (lane_ill[k])
    );
  end

  // Valid lanes are compacted: each takes the slot after all lower-numbered valid lanes.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < FetchWidth; k++) begin
      lane_rank[k] = push_cnt;
      lane_slot[k] = tail_q + PtrW'(push_cnt);
      if (fetchLaneMask_i[k]) push_cnt = push_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (pop)  head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + PtrW'(push_cnt);
      occ_q <= occ_q + (push ? CntW'(push_cnt) : CntW'(0)) - CntW'(pop);
    end
  end

  always_ff @(posedge clock_i) begin
    for (int k = 0; k < FetchWidth; k++) begin
      if (push && fetchLaneMask_i[k]) begin
        ins_mem[lane_slot[k]]  <= instructions_i[k*instructionWidth +: instructionWidth];
        addr_mem[lane_slot[k]] <= baseAddress_i + (addressWidth'(k) << 2);
        maj_mem[lane_slot[k]]  <= baseMajId_i + instructionCounterWidth'(lane_rank[k]);
        pid_mem[lane_slot[k]]  <= instructionPid_i;
        tid_mem[lane_slot[k]]  <= instructionTid_i;
        fmt_mem[lane_slot[k]]  <= lane_fmt[k];
        ill_mem[lane_slot[k]]  <= lane_ill[k];
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      oe_q   <= 1'b0;
      ill_q  <= 1'b0;
      fmt_q  <= '0;
      ins_q  <= '0;
      addr_q <= '0;
      maj_q  <= '0;
      pid_q  <= '0;
      tid_q  <= '0;
    end else if (flush_i) begin
      oe_q <= 1'b0;
    end else if (!stall_i) begin
      oe_q <= pop;
      if (pop) begin
        ill_q  <= ill_mem[head_q];
        fmt_q  <= fmt_mem[head_q];
        ins_q  <= ins_mem[head_q];
        addr_q <= addr_mem[head_q];
        maj_q  <= maj_mem[head_q];
        pid_q  <= pid_mem[head_q];
        tid_q  <= tid_mem[head_q];
      end
    end
  end

  assign outputEnable_o       = oe_q;
  assign instFormat_o         = fmt_q;
  assign instOpcode_o         = ins_q[instructionWidth-1 -: opcodeSize];
  assign instruction_o        = ins_q;
  assign instructionAddress_o = addr_q;
  assign instructionPid_o     = pid_q;
  assign instructionTid_o     = tid_q;
  assign instructionMajId_o   = maj_q;
  assign illegal_o            = ill_q;
  assign occupancy_o          = occ_q;

endmodule

// File: tb/tb_format_scan_queue.sv
// Directed and randomized bench for format_scan_queue against a queue-based reference model.
module tb_format_scan_queue;

  localparam int FW  = 4;
  localparam int DEP = 16;

  logic         clk = 1'b0, rstn = 1'b0, flush = 1'b0, fv = 1'b0, stall = 1'b0;
  logic [3:0]   mask = '0;
  logic [127:0] ins = '0;
  logic [63:0]  base = '0, maj = '0;
  logic [19:0]  pid = '0;
  logic [15:0]  tid = '0;

  logic         ready, oe, ill;
  logic [24:0]  fmt;
  logic [5:0]   op;
  logic [31:0]  oins;
  logic [63:0]  oaddr, omaj;
  logic [19:0]  opid;
  logic [15:0]  otid;
  logic [4:0]   occ;

  always #5 clk = ~clk;

  format_scan_queue dut (
    .clock_i              (clk),
    .resetn_i             (rstn),
    .flush_i              (flush),
    .fetchValid_i         (fv),
    .fetchLaneMask_i      (mask),
    .instructions_i       (ins),
    .baseAddress_i        (base),
    .instructionPid_i     (pid),
    .instructionTid_i     (tid),
    .baseMajId_i          (maj),
    .fetchReady_o         (ready),
    .stall_i              (stall),
    .outputEnable_o       (oe),
    .instFormat_o         (fmt),
    .instOpcode_o         (op),
    .instruction_o        (oins),
    .instructionAddress_o (oaddr),
    .instructionPid_o     (opid),
    .instructionTid_o     (otid),
    .instructionMajId_o   (omaj),
    .illegal_o            (ill),
    .occupancy_o          (occ)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] addr;
    logic [63:0] maj;
    logic [19:0] pid;
    logic [15:0] tid;
  } ent_t;

  ent_t q[$];
  ent_t exp_out;
  bit   exp_valid = 1'b0;
  int   vectors = 0, miscompares = 0;

  function automatic logic [24:0] fmt_of(input logic [5:0] o);
    case (o)
      6'd18:   return 25'h40;
      6'd16:   return 25'h2;
      6'd17:   return 25'h400;
      6'd14:   return 25'h4;
      6'd30:   return 25'h300;
      default: return 25'h0;
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6] = '{6'd18, 6'd16, 6'd17, 6'd14, 6'd30, 6'd0};
    return ops[$urandom_range(5)];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_group(input bit v, input logic [3:0] m, input logic [5:0] o0,
                           input logic [5:0] o1, input logic [5:0] o2, input logic [5:0] o3,
                           input logic [63:0] b, input logic [63:0] mj);
    logic [5:0] o [4];
    o[0] = o0; o[1] = o1; o[2] = o2; o[3] = o3;
    for (int k = 0; k < 4; k++) ins[k*32 +: 32] = {o[k], 26'($urandom)};
    fv = v; mask = m; base = b; maj = mj;
    pid = 20'($urandom); tid = 16'($urandom);
  endtask

  task automatic set_random(input logic [3:0] m);
    set_group(1'b1, m, rand_op(), rand_op(), rand_op(), rand_op(),
              {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // One clock edge of the reference: pop from the front, append accepted lanes in order.
  task automatic model_edge();
    int   sz;
    int   rank;
    bit   acc;
    ent_t e;
    sz = q.size();
    if (flush) begin
      q.delete();
      exp_valid = 1'b0;
      return;
    end
    acc = fv && ((DEP - sz) >= FW);
    if (!stall) begin
      if (sz > 0) begin
        exp_out   = q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (acc) begin
      rank = 0;
      for (int k = 0; k < FW; k++) begin
        if (mask[k]) begin
          e.ins  = ins[k*32 +: 32];
          e.addr = base + 64'(4 * k);
          e.maj  = maj + 64'(rank);
          e.pid  = pid;
          e.tid  = tid;
          q.push_back(e);
          rank++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_en", 64'(oe), 64'(exp_valid));
    chk("occupancy", 64'(occ), 64'(q.size()));
    chk("ready", 64'(ready), 64'((DEP - q.size()) >= FW));
    if (exp_valid) begin
      chk("format", 64'(fmt), 64'(fmt_of(exp_out.ins[31:26])));
      chk("opcode", 64'(op), 64'(exp_out.ins[31:26]));
      chk("instr", 64'(oins), 64'(exp_out.ins));
      chk("addr", oaddr, exp_out.addr);
      chk("majid", omaj, exp_out.maj);
      chk("pid", 64'(opid), 64'(exp_out.pid));
      chk("tid", 64'(otid), 64'(exp_out.tid));
      chk("illegal", 64'(ill), 64'(fmt_of(exp_out.ins[31:26]) == 25'h0));
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'h0);
    chk({tag, "_oe"}, 64'(oe), 64'h0);
    chk({tag, "_fmt"}, 64'(fmt), 64'h0);
    chk({tag, "_op"}, 64'(op), 64'h0);
    chk({tag, "_ins"}, 64'(oins), 64'h0);
    chk({tag, "_addr"}, oaddr, 64'h0);
    chk({tag, "_pid"}, 64'(opid), 64'h0);
    chk({tag, "_tid"}, 64'(otid), 64'h0);
    chk({tag, "_maj"}, omaj, 64'h0);
    chk({tag, "_ill"}, 64'(ill), 64'h0);
    chk({tag, "_occ"}, 64'(occ), 64'h0);
  endtask

  initial begin
    // Reset state, then release away from a clock edge.
    #12;
    check_zero("rst");
    rstn = 1'b1;
    #1;
    chk("rst_release_ready", 64'(ready), 64'h1);
    cycle(1);

    // Single full group with the classification anchors.
    set_group(1'b1, 4'b1111, 6'd18, 6'd16, 6'd17, 6'd14, 64'h1000, 64'd100);
    cycle(1);
    fv = 1'b0;
    cycle(1);
    chk("g1_first_addr", oaddr, 64'h1000);
    chk("g1_first_fmt", 64'(fmt), 64'h40);
    cycle(5);

    // Sparse lane mask: physical lane addressing, rank-based MajId.
    set_group(1'b1, 4'b1010, rand_op(), rand_op(), rand_op(), rand_op(), 64'h2000, 64'd7);
    cycle(1);
    fv = 1'b0;
    cycle(1);
    chk("sparse_addr0", oaddr, 64'h2004);
    chk("sparse_maj0", omaj, 64'd7);
    cycle(1);
    chk("sparse_addr1", oaddr, 64'h200C);
    chk("sparse_maj1", omaj, 64'd8);
    cycle(2);

    // Fill under stall; a fifth group must be refused.
    stall = 1'b1;
    for (int g = 0; g < 4; g++) begin
      set_random(4'b1111);
      cycle(1);
    end
    chk("fill_occ", 64'(occ), 64'd16);
    chk("fill_ready", 64'(ready), 64'h0);
    set_random(4'b1111);
    cycle(2);
    fv = 1'b0;
    stall = 1'b0;
    cycle(18);

    // Steady state: one lane in, one out, across pointer wrap.
    set_group(1'b1, 4'b1111, rand_op(), rand_op(), rand_op(), rand_op(), 64'h3000, 64'd500);
    cycle(1);
    for (int i = 0; i < 22; i++) begin
      set_random(4'(1 << $urandom_range(3)));
      maj = 64'd504 + 64'(i);
      cycle(1);
      chk("steady_occ", 64'(occ), 64'd4);
    end
    fv = 1'b0;
    cycle(6);

    // Flush with nine buffered entries and a same-cycle push.
    stall = 1'b1;
    set_random(4'b1111); cycle(1);
    set_random(4'b1111); cycle(1);
    set_random(4'b0001); cycle(1);
    chk("pre_flush_occ", 64'(occ), 64'd9);
    set_random(4'b1111);
    flush = 1'b1;
    cycle(1);
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_oe", 64'(oe), 64'h0);
    chk("flush_ready", 64'(ready), 64'h1);
    flush = 1'b0;
    fv = 1'b0;
    stall = 1'b0;
    cycle(6);

    // Illegal opcode 0.
    set_group(1'b1, 4'b0001, 6'd0, 6'd18, 6'd18, 6'd18, 64'h4000, 64'd900);
    cycle(1);
    fv = 1'b0;
    cycle(1);
    chk("op0_illegal", 64'(ill), 64'h1);
    chk("op0_fmt", 64'(fmt), 64'h0);

    // Randomized traffic with random stalls and masks.
    for (int i = 0; i < 60; i++) begin
      set_random(4'($urandom));
      fv    = ($urandom_range(2) != 0);
      stall = ($urandom_range(3) == 0);
      cycle(1);
    end

    // Asynchronous reset mid-stream, between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    exp_valid = 1'b0;
    fv = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", 64'(ready), 64'h1);
    set_random(4'b0111);
    cycle(1);
    fv = 1'b0;
    cycle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
